// File: rtl/reset_pc_sequencer_if.sv
// Fetch-control bundle between the pipeline control logic and the PC sequencer.
// The master drives stall/redirect requests. The slave returns the fetch
// address, the chip enable and the status flags.
interface reset_pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              branch_flag;
  logic [ADDR_W-1:0] branch_target;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic              stalled;
  logic              misalign;

  modport master (
    output stall, branch_flag, branch_target, flush, new_pc,
    input  pc, ce, stalled, misalign
  );

  modport slave (
    input  stall, branch_flag, branch_target, flush, new_pc,
    output pc, ce, stalled, misalign
  );
endinterface

// File: rtl/reset_pc_sequencer.sv
// Fetch PC sequencer.
// After reset it waits one edge in IDLE, then fetches from RESET_VEC.
// Redirect priority: flush, then stall, then branch, then pending branch, then
// sequential. A branch that arrives while stalled is parked in a one-entry
// pending register. It is replayed when the stall drops.
module reset_pc_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                STEP      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  reset_pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  localparam logic [ADDR_W-1:0] STEP_INC   = ADDR_W'(STEP);
  // STEP is a power of two, so STEP-1 selects the low log2(STEP) bits.
  // This also covers STEP=1, where the mask is empty.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic              ce_q, ce_n;
  logic              stalled_q, stalled_n;
  logic              pend_valid, pend_valid_n;
  logic [ADDR_W-1:0] pend_tgt, pend_tgt_n;

  // State and output registers. Reset clears everything at once, without
  // waiting for a clock edge, including any parked branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc_q       <= RESET_VEC;
      ce_q       <= 1'b0;
      stalled_q  <= 1'b0;
      pend_valid <= 1'b0;
      pend_tgt   <= '0;
    end else begin
      state      <= state_n;
      pc_q       <= pc_n;
      ce_q       <= ce_n;
      stalled_q  <= stalled_n;
      pend_valid <= pend_valid_n;
      pend_tgt   <= pend_tgt_n;
    end
  end

  // Next-state and next-PC selection. Priority: flush, stall, branch, pending
  // branch, then sequential.
  always_comb begin
    state_n      = state;
    pc_n         = pc_q;
    pend_valid_n = pend_valid;
    pend_tgt_n   = pend_tgt;

    unique case (state)
      IDLE: begin
        // All redirect inputs are ignored here.
        // pc stays at RESET_VEC, so the first fetch uses RESET_VEC.
        state_n = RUN;
      end
      RUN, HOLD: begin
        if (bus.flush) begin
          pc_n         = bus.new_pc;
          pend_valid_n = 1'b0;
          state_n      = RUN;
        end else if (bus.stall) begin
          // Hold pc. The newest branch seen during the stall wins.
          state_n = HOLD;
          if (bus.branch_flag) begin
            pend_tgt_n   = bus.branch_target;
            pend_valid_n = 1'b1;
          end
        end else if (bus.branch_flag) begin
          pc_n         = bus.branch_target;
          pend_valid_n = 1'b0;
          state_n      = RUN;
        end else if (pend_valid) begin
          pc_n         = pend_tgt;
          pend_valid_n = 1'b0;
          state_n      = RUN;
        end else begin
          // Wraps modulo 2^ADDR_W without raising any flag.
          pc_n    = pc_q + STEP_INC;
          state_n = RUN;
        end
      end
      default: begin
        // An unreachable encoding falls back to a clean restart.
        state_n      = IDLE;
        pc_n         = RESET_VEC;
        pend_valid_n = 1'b0;
        pend_tgt_n   = '0;
      end
    endcase

    ce_n      = (state_n != IDLE);
    stalled_n = (state_n == HOLD);
  end

  assign bus.pc      = pc_q;
  assign bus.ce      = ce_q;
  assign bus.stalled = stalled_q;
  // Flags a misaligned pc for the exception unit. It does not alter the
  // sequence; the exception unit is expected to flush.
  assign bus.misalign = ce_q && ((pc_q & ALIGN_MASK) != '0);

endmodule

// File: tb/tb_reset_pc_sequencer.sv
// Directed bench for reset_pc_sequencer (ADDR_W=32, RESET_VEC=0, STEP=4).
module tb_reset_pc_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passes = 0;

  reset_pc_sequencer_if #(.ADDR_W(32)) bus ();

  reset_pc_sequencer #(
    .ADDR_W   (32),
    .RESET_VEC(32'h0000_0000),
    .STEP     (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    else
      passes++;
  endtask

  // Advance one edge and sample 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                       input logic fl, input logic [31:0] np);
    bus.stall         = st;
    bus.branch_flag   = br;
    bus.branch_target = bt;
    bus.flush         = fl;
    bus.new_pc        = np;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    #2;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_ce", {31'b0, bus.ce}, 32'd0);
    chk("rst_stalled", {31'b0, bus.stalled}, 32'd0);
    chk("rst_misalign", {31'b0, bus.misalign}, 32'd0);
    step();
    chk("rst_hold_ce", {31'b0, bus.ce}, 32'd0);

    // Release reset between edges. Nothing may change until the next edge.
    #3 rst = 1'b1;
    #1 chk("release_ce", {31'b0, bus.ce}, 32'd0);
    chk("release_pc", bus.pc, 32'h0);

    // Start-up sequence: ce 0,1,1,1 and pc 0,0,4,8,C.
    step(); chk("boot1_ce", {31'b0, bus.ce}, 32'd1); chk("boot1_pc", bus.pc, 32'h0);
    step(); chk("boot2_ce", {31'b0, bus.ce}, 32'd1); chk("boot2_pc", bus.pc, 32'h4);
    step(); chk("boot3_pc", bus.pc, 32'h8);
    step(); chk("boot4_pc", bus.pc, 32'hC);
    step(); chk("seq_pc", bus.pc, 32'h10);

    // Three-cycle stall, with a branch to 0x200 in stall cycle 2.
    drive(1, 0, 0, 0, 0);
    step(); chk("st1_pc", bus.pc, 32'h10); chk("st1_stalled", {31'b0, bus.stalled}, 32'd1);
    drive(1, 1, 32'h200, 0, 0);
    step(); chk("st2_pc", bus.pc, 32'h10); chk("st2_stalled", {31'b0, bus.stalled}, 32'd1);
    drive(1, 0, 0, 0, 0);
    step(); chk("st3_pc", bus.pc, 32'h10);
    drive(0, 0, 0, 0, 0);
    step(); chk("pend_pc", bus.pc, 32'h200); chk("pend_stalled", {31'b0, bus.stalled}, 32'd0);
    step(); chk("pend_next", bus.pc, 32'h204);

    // A flush during a stall overrides the stall and drops the parked branch.
    drive(0, 0, 0, 1, 32'h20);
    step(); chk("fl20_pc", bus.pc, 32'h20);
    drive(1, 1, 32'h300, 0, 0);
    step(); chk("park300_pc", bus.pc, 32'h20); chk("park300_st", {31'b0, bus.stalled}, 32'd1);
    drive(1, 0, 0, 1, 32'h80);
    step(); chk("flst_pc", bus.pc, 32'h80); chk("flst_stalled", {31'b0, bus.stalled}, 32'd0);
    drive(0, 0, 0, 0, 0);
    step(); chk("flst_next", bus.pc, 32'h84);

    // pc wraps from the top of the address space to 0.
    drive(0, 0, 0, 1, 32'hFFFF_FFFC);
    step(); chk("top_pc", bus.pc, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 0);
    step(); chk("wrap_pc", bus.pc, 32'h0); chk("wrap_ce", {31'b0, bus.ce}, 32'd1);

    // A misaligned branch raises misalign; a later flush clears it.
    drive(0, 1, 32'h102, 0, 0);
    step(); chk("mis_pc", bus.pc, 32'h102); chk("mis_flag", {31'b0, bus.misalign}, 32'd1);
    drive(0, 0, 0, 1, 32'h180);
    step(); chk("mis_fix_pc", bus.pc, 32'h180); chk("mis_fix_flag", {31'b0, bus.misalign}, 32'd0);

    // flush beats branch in the same cycle.
    drive(0, 1, 32'h600, 1, 32'h500);
    step(); chk("prio_pc", bus.pc, 32'h500);

    // Reset pulse in HOLD with 0x400 parked: the parked branch must be lost.
    drive(1, 1, 32'h400, 0, 0);
    step(); chk("h400_pc", bus.pc, 32'h500);
    drive(1, 0, 0, 0, 0);
    step(); chk("h400_st", {31'b0, bus.stalled}, 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_pc", bus.pc, 32'h0);
    chk("arst_ce", {31'b0, bus.ce}, 32'd0);
    chk("arst_stalled", {31'b0, bus.stalled}, 32'd0);
    chk("arst_misalign", {31'b0, bus.misalign}, 32'd0);
    drive(0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1 chk("arel_ce", {31'b0, bus.ce}, 32'd0);
    step(); chk("re1_ce", {31'b0, bus.ce}, 32'd1); chk("re1_pc", bus.pc, 32'h0);
    step(); chk("re2_pc", bus.pc, 32'h4);
    step(); chk("re3_pc", bus.pc, 32'h8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/reset_pc_sequencer.md
RESET_PC_SEQUENCER -- requirements
Module: reset_pc_sequencer

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32, width of every address port.
REQ-002 SHALL provide parameter RESET_VEC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL provide parameter STEP, default 4, sequential increment in bytes; power of two, at least 1.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 SHALL have port stall  input  1  pipeline stall; holds pc.
REQ-007 SHALL have port branch_flag  input  1  branch/jump taken this cycle.
REQ-008 SHALL have port branch_target  input  ADDR_W  branch/jump destination.
REQ-009 SHALL have port flush  input  1  exception/interrupt redirect; highest priority.
REQ-010 SHALL have port new_pc  input  ADDR_W  flush destination.
REQ-011 SHALL have port pc  output  ADDR_W  registered fetch address.
REQ-012 SHALL have port ce  output  1  registered instruction-memory chip enable.
REQ-013 SHALL have port stalled  output  1  registered, high while in HOLD.
REQ-014 SHALL have port misalign  output  1  combinational, ce high and pc low log2(STEP) bits nonzero.

Function
REQ-015 SHALL implement three states: IDLE (after reset, ce=0), RUN (fetching), HOLD (fetching held by stall).
REQ-016 IDLE: first clk edge with rst=1 SHALL move to RUN and set ce=1; pc SHALL stay RESET_VEC, so the first fetch is RESET_VEC.
REQ-017 In IDLE, stall, branch_flag and flush SHALL be ignored.
REQ-018 In RUN/HOLD, next-pc priority SHALL be: flush > stall > branch_flag > pending redirect > sequential.
REQ-019 flush=1: pc<=new_pc, pending redirect cleared, next state RUN, regardless of stall.
REQ-020 stall=1 (no flush): pc held, next state HOLD; branch_flag=1 in the same cycle SHALL latch branch_target into a one-entry pending register, pend_valid<=1; a later branch while stalled SHALL overwrite it (newest wins).
REQ-021 stall=0, branch_flag=1: pc<=branch_target, pend_valid<=0, next state RUN.
REQ-022 stall=0, branch_flag=0, pend_valid=1: pc<=pending target, pend_valid<=0, next state RUN.
REQ-023 Otherwise: pc<=pc+STEP, modulo 2^ADDR_W (all-ones region wraps to 0, no flag), next state RUN.
REQ-024 stalled SHALL equal (state==HOLD); it rises the cycle after the first stall=1 edge and falls the cycle after stall=0.
REQ-025 misalign SHALL NOT alter the sequence; pc is forwarded unchanged for the exception unit to flush.
REQ-026 Latency from any redirect input to pc SHALL be exactly one clk edge.

Reset
REQ-027 rst=0 SHALL immediately, without clk: pc=RESET_VEC, ce=0, stalled=0, pend_valid=0, pending target=0, state IDLE; misalign therefore 0.
REQ-028 Reset asserted mid-operation, including in HOLD with a pending redirect, SHALL discard all state; release SHALL restart from REQ-016.
REQ-029 Reset release SHALL be taken on the next rising clk edge only; no output SHALL change on the release edge itself.

Verification
REQ-030 Reset release, RESET_VEC=0, STEP=4, no stimulus -> ce 0,1,1,1; pc 0,0,4,8,0xC on successive edges.
REQ-031 pc=0x10, stall=1 for 3 cycles with branch_flag=1/target=0x200 in stall cycle 2 -> pc holds 0x10, stalled=1; after stall drops pc=0x200, then 0x204.
REQ-032 pc=0x20, stall=1, flush=1, new_pc=0x80 same cycle, pending=0x300 held -> pc=0x80, pend_valid=0, stalled=0; next 0x84 with stall=0.
REQ-033 ADDR_W=32, pc=0xFFFF_FFFC, no stimulus -> next pc=0x0000_0000, ce stays 1.
REQ-034 branch_target=0x102 taken -> pc=0x102, misalign=1; flush to 0x180 next cycle -> pc=0x180, misalign=0.
REQ-035 rst=0 pulsed between edges in HOLD with pending=0x400 -> outputs reset immediately; after release first fetch RESET_VEC, 0x400 never appears.
